// File: rtl/fifo_action_driver_if.sv
// Agent action channel plus the fifo-facing push/pop/data and edge-flag signals.
// The slave modport is the driver's view; the master modport belongs to the agent/fifo side.
interface fifo_action_driver_if #(
    parameter int width = 8,
    parameter int lenw  = 4
);
    logic             act_valid;
    logic             act_ready;
    logic [1:0]       act_op;
    logic [lenw-1:0]  act_len;
    logic             fifo_push;
    logic             fifo_pop;
    logic [width-1:0] fifo_datain;
    logic             fifo_full_posedge;
    logic             fifo_empty_posedge;

    modport master (
        output act_valid, act_op, act_len, fifo_full_posedge, fifo_empty_posedge,
        input  act_ready, fifo_push, fifo_pop, fifo_datain
    );

    modport slave (
        input  act_valid, act_op, act_len, fifo_full_posedge, fifo_empty_posedge,
        output act_ready, fifo_push, fifo_pop, fifo_datain
    );
endinterface

// File: rtl/fifo_action_driver.sv
// Turns agent action tokens into registered fifo push/pop/data; rewards and ends the episode on the goal edge.
// Latency: one cycle from token accept to first push/pop; backpressure: act_ready only while IDLE.
module fifo_action_driver #(
    parameter int width     = 8,
    parameter int depth     = 16,
    parameter int log2depth = 4,
    parameter int lenw      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_action_driver_if.slave  bus,
    input  logic                 goal_sel,
    input  logic                 ep_clear,
    output logic                 reward,
    output logic                 done,
    output logic [15:0]          step_cnt
);
    localparam int occw = log2depth + 1;
    localparam logic [occw-1:0] occ_max = occw'(depth);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t           state;
    state_t           state_n;
    logic [1:0]       cur_op;
    logic [lenw-1:0]  remaining;
    logic             push_drv;
    logic             pop_drv;
    logic [width-1:0] data_cnt;
    logic [occw-1:0]  occ;
    logic [occw-1:0]  occ_next;
    logic             goal_hit;
    logic             accepting;
    logic [1:0]       op_sel;
    logic             push_next;
    logic             pop_next;

    assign goal_hit = (goal_sel ? bus.fifo_empty_posedge : bus.fifo_full_posedge) && (state != DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (goal_hit) state_n = DONE;
                     else if (bus.act_valid) state_n = RUN;
            RUN:     if (goal_hit) state_n = DONE;
                     else if (remaining == '0) state_n = IDLE;
            DONE:    if (ep_clear) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next-cycle push/pop come from the shadow occupancy, never from the fifo's own outputs.
    always_comb begin
        accepting = (state == IDLE);
        done      = (state == DONE);
        op_sel    = (state == IDLE) ? bus.act_op : cur_op;
        occ_next  = occ + occw'(push_drv) - occw'(pop_drv);
        pop_next  = (state_n == RUN) && op_sel[1] && (occ_next != '0);
        push_next = (state_n == RUN) && op_sel[0] && ((occ_next < occ_max) || pop_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_op    <= '0;
            remaining <= '0;
            push_drv  <= 1'b0;
            pop_drv   <= 1'b0;
            data_cnt  <= '0;
            occ       <= '0;
            reward    <= 1'b0;
            step_cnt  <= '0;
        end else begin
            occ      <= occ_next;
            push_drv <= push_next;
            pop_drv  <= pop_next;
            reward   <= goal_hit;
            if (push_drv)
                data_cnt <= data_cnt + width'(1);
            if (state == IDLE && bus.act_valid) begin
                cur_op    <= bus.act_op;
                remaining <= bus.act_len;
            end else if (state == RUN && remaining != '0) begin
                remaining <= remaining - lenw'(1);
            end
            if (state == DONE && ep_clear)
                step_cnt <= '0;
            else if (state == RUN && step_cnt != 16'hFFFF)
                step_cnt <= step_cnt + 16'd1;
        end
    end

    assign bus.act_ready   = accepting;
    assign bus.fifo_push   = push_drv;
    assign bus.fifo_pop    = pop_drv;
    assign bus.fifo_datain = data_cnt;
endmodule

// File: tb/tb_fifo_action_driver.sv
// Directed bench for fifo_action_driver with a behavioural 16-deep fifo supplying the full/empty edge flags.
module tb_fifo_action_driver;
    logic        clk = 1'b0;
    logic        rst;
    logic        goal_sel;
    logic        ep_clear;
    logic        reward;
    logic        done;
    logic [15:0] step_cnt;

    fifo_action_driver_if #(.width(8), .lenw(4)) bus();

    fifo_action_driver #(.width(8), .depth(16), .log2depth(4), .lenw(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .goal_sel(goal_sel), .ep_clear(ep_clear),
        .reward(reward), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Fifo model: occupancy and registered rising-edge flags of full/empty.
    int fcnt;
    int nc;
    bit pop_ok;
    bit push_ok;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            fcnt <= 0;
            bus.fifo_full_posedge  <= 1'b0;
            bus.fifo_empty_posedge <= 1'b0;
        end else begin
            pop_ok  = (bus.fifo_pop === 1'b1) && (fcnt > 0);
            push_ok = (bus.fifo_push === 1'b1) && ((fcnt < 16) || pop_ok);
            nc = fcnt + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
            fcnt <= nc;
            bus.fifo_full_posedge  <= (nc == 16) && (fcnt != 16);
            bus.fifo_empty_posedge <= (nc == 0) && (fcnt != 0);
        end
    end

    // Monitor, sampled on the falling edge; counters are cumulative and tests diff them.
    int cyc = 0, push_n = 0, pop_n = 0, reward_n = 0, ovf_n = 0, unf_n = 0;
    int full_cyc = -10, empty_cyc = -10, reward_cyc = -20;
    logic [7:0] push_log[$];
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (bus.fifo_push === 1'b1) begin
                push_log.push_back(bus.fifo_datain);
                push_n++;
                if (fcnt >= 16 && bus.fifo_pop !== 1'b1) ovf_n++;
            end
            if (bus.fifo_pop === 1'b1) begin
                pop_n++;
                if (fcnt == 0) unf_n++;
            end
            if (bus.fifo_full_posedge === 1'b1) full_cyc = cyc;
            if (bus.fifo_empty_posedge === 1'b1) empty_cyc = cyc;
            if (reward === 1'b1) begin
                reward_n++;
                reward_cyc = cyc;
            end
        end
        cyc++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        goal_sel = 1'b0;
        ep_clear = 1'b0;
        bus.act_valid = 1'b0;
        bus.act_op = 2'b00;
        bus.act_len = 4'd0;
        wait_cyc(2);
        rst = 1'b1;
        wait_cyc(1);
    endtask

    task automatic send(input logic [1:0] op, input logic [3:0] len);
        bit got = 0;
        bus.act_valid = 1'b1;
        bus.act_op = op;
        bus.act_len = len;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.act_ready === 1'b1) got = 1;
        end
        @(posedge clk);
        #1;
        bus.act_valid = 1'b0;
        tests_run++;
        if (!got) begin tests_failed++; $display("FAIL send_accept: act_ready got 0 want 1 within 60 cycles"); end
    endtask

    task automatic wait_done(input int limit);
        bit seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            wait_cyc(1);
            if (done === 1'b1) seen = 1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL wait_done: done got %b want 1 within %0d cycles", done, limit); end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.fifo_push !== 1'b0) begin tests_failed++; $display("FAIL reset_push: got %b want 0", bus.fifo_push); end
        tests_run++; if (bus.fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL reset_pop: got %b want 0", bus.fifo_pop); end
        tests_run++; if (bus.fifo_datain !== 8'd0) begin tests_failed++; $display("FAIL reset_datain: got %0d want 0", bus.fifo_datain); end
        tests_run++; if (reward !== 1'b0) begin tests_failed++; $display("FAIL reset_reward: got %b want 0", reward); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", done); end
        tests_run++; if (step_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_step: got %0d want 0", step_cnt); end
        tests_run++; if (bus.act_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", bus.act_ready); end
    endtask

    task automatic test_push_to_full();
        int p0, r0, idx;
        do_reset();
        p0 = push_n; r0 = reward_n;
        send(2'b01, 4'd15);
        wait_done(40);
        wait_cyc(4);
        tests_run++; if (push_n - p0 != 16) begin tests_failed++; $display("FAIL full_pushes: got %0d want 16", push_n - p0); end
        for (int i = 0; i < 16; i++) begin
            idx = p0 + i;
            tests_run++;
            if (idx >= push_log.size() || push_log[idx] !== 8'(i)) begin
                tests_failed++; $display("FAIL full_data[%0d]: got %0d want %0d", i, (idx < push_log.size()) ? int'(push_log[idx]) : -1, i);
            end
        end
        tests_run++; if (reward_n - r0 != 1) begin tests_failed++; $display("FAIL full_reward_cnt: got %0d want 1", reward_n - r0); end
        tests_run++; if (reward_cyc != full_cyc + 1) begin tests_failed++; $display("FAIL full_reward_lag: got %0d want %0d", reward_cyc - full_cyc, 1); end
        tests_run++; if (done !== 1'b1) begin tests_failed++; $display("FAIL full_done: got %b want 1", done); end
        tests_run++; if (step_cnt !== 16'd16) begin tests_failed++; $display("FAIL full_step: got %0d want 16", step_cnt); end
        tests_run++; if (bus.fifo_push !== 1'b0) begin tests_failed++; $display("FAIL full_push_low: got %b want 0", bus.fifo_push); end
        tests_run++; if (bus.act_ready !== 1'b0) begin tests_failed++; $display("FAIL full_ready_low: got %b want 0", bus.act_ready); end
    endtask

    task automatic test_overfill();
        int p0, r0, o0;
        do_reset();
        goal_sel = 1'b1;
        p0 = push_n; r0 = reward_n; o0 = ovf_n;
        send(2'b01, 4'd7);
        send(2'b01, 4'd15);
        wait_cyc(24);
        tests_run++; if (push_n - p0 != 16) begin tests_failed++; $display("FAIL over_pushes: got %0d want 16", push_n - p0); end
        tests_run++; if (ovf_n - o0 != 0) begin tests_failed++; $display("FAIL over_push_when_full: got %0d want 0", ovf_n - o0); end
        tests_run++; if (reward_n - r0 != 0) begin tests_failed++; $display("FAIL over_reward: got %0d want 0", reward_n - r0); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL over_done: got %b want 0", done); end
        tests_run++; if (step_cnt !== 16'd24) begin tests_failed++; $display("FAIL over_step: got %0d want 24", step_cnt); end
        tests_run++; if (fcnt != 16) begin tests_failed++; $display("FAIL over_fifo_cnt: got %0d want 16", fcnt); end
    endtask

    task automatic test_pop_to_empty();
        int q0, r0, u0;
        do_reset();
        goal_sel = 1'b1;
        q0 = pop_n; r0 = reward_n; u0 = unf_n;
        send(2'b01, 4'd3);
        send(2'b10, 4'd7);
        wait_done(30);
        wait_cyc(3);
        tests_run++; if (pop_n - q0 != 4) begin tests_failed++; $display("FAIL empty_pops: got %0d want 4", pop_n - q0); end
        tests_run++; if (unf_n - u0 != 0) begin tests_failed++; $display("FAIL empty_pop_when_empty: got %0d want 0", unf_n - u0); end
        tests_run++; if (reward_n - r0 != 1) begin tests_failed++; $display("FAIL empty_reward_cnt: got %0d want 1", reward_n - r0); end
        tests_run++; if (reward_cyc != empty_cyc + 1) begin tests_failed++; $display("FAIL empty_reward_lag: got %0d want 1", reward_cyc - empty_cyc); end
        tests_run++; if (step_cnt !== 16'd9) begin tests_failed++; $display("FAIL empty_step: got %0d want 9", step_cnt); end
        tests_run++; if (bus.fifo_pop !== 1'b0) begin tests_failed++; $display("FAIL empty_pop_low: got %b want 0", bus.fifo_pop); end
    endtask

    task automatic test_push_pop();
        int p0, q0, r0, idx;
        do_reset();
        p0 = push_n; q0 = pop_n; r0 = reward_n;
        send(2'b11, 4'd5);
        wait_cyc(8);
        tests_run++; if (push_n - p0 != 6) begin tests_failed++; $display("FAIL pp_pushes: got %0d want 6", push_n - p0); end
        tests_run++; if (pop_n - q0 != 5) begin tests_failed++; $display("FAIL pp_pops: got %0d want 5", pop_n - q0); end
        for (int i = 0; i < 6; i++) begin
            idx = p0 + i;
            tests_run++;
            if (idx >= push_log.size() || push_log[idx] !== 8'(i)) begin
                tests_failed++; $display("FAIL pp_data[%0d]: got %0d want %0d", i, (idx < push_log.size()) ? int'(push_log[idx]) : -1, i);
            end
        end
        tests_run++; if (fcnt != 1) begin tests_failed++; $display("FAIL pp_fifo_cnt: got %0d want 1", fcnt); end
        tests_run++; if (reward_n - r0 != 0) begin tests_failed++; $display("FAIL pp_reward: got %0d want 0", reward_n - r0); end
        tests_run++; if (step_cnt !== 16'd6) begin tests_failed++; $display("FAIL pp_step: got %0d want 6", step_cnt); end
    endtask

    task automatic test_reset_mid_run();
        int q0;
        do_reset();
        send(2'b01, 4'd15);
        wait_cyc(3);
        rst = 1'b0;
        #1;
        tests_run++; if (bus.fifo_push !== 1'b0) begin tests_failed++; $display("FAIL mid_push: got %b want 0", bus.fifo_push); end
        tests_run++; if (bus.fifo_datain !== 8'd0) begin tests_failed++; $display("FAIL mid_datain: got %0d want 0", bus.fifo_datain); end
        tests_run++; if (step_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_step: got %0d want 0", step_cnt); end
        wait_cyc(1);
        rst = 1'b1;
        wait_cyc(1);
        tests_run++; if (bus.act_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_ready: got %b want 1", bus.act_ready); end
        q0 = pop_n;
        send(2'b10, 4'd2);
        wait_cyc(5);
        tests_run++; if (pop_n - q0 != 0) begin tests_failed++; $display("FAIL mid_occ_zero_pops: got %0d want 0", pop_n - q0); end
    endtask

    task automatic test_back_to_back();
        int p0;
        do_reset();
        p0 = push_n;
        bus.act_op = 2'b01;
        bus.act_len = 4'd1;
        bus.act_valid = 1'b1;
        wait_done(80);
        wait_cyc(6);
        tests_run++; if (push_n - p0 != 16) begin tests_failed++; $display("FAIL b2b_pushes: got %0d want 16", push_n - p0); end
        tests_run++; if (bus.act_ready !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_done: got %b want 0", bus.act_ready); end
        tests_run++; if (step_cnt !== 16'd16) begin tests_failed++; $display("FAIL b2b_step: got %0d want 16", step_cnt); end
        bus.act_valid = 1'b0;
        ep_clear = 1'b1;
        wait_cyc(1);
        ep_clear = 1'b0;
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL clr_done: got %b want 0", done); end
        tests_run++; if (step_cnt !== 16'd0) begin tests_failed++; $display("FAIL clr_step: got %0d want 0", step_cnt); end
        tests_run++; if (bus.act_ready !== 1'b1) begin tests_failed++; $display("FAIL clr_ready: got %b want 1", bus.act_ready); end
    endtask

    initial begin
        test_reset();
        test_push_to_full();
        test_overfill();
        test_pop_to_empty();
        test_push_pop();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
